// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame defaults, mode-0 clocking constants and the
// responder FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_WIDTH_DEFAULT     = 8;
    localparam logic [7:0]  SPI_IDLE_FILL_DEFAULT = 8'hFF;

    // Mode 0: sclk idles low, data sampled on the leading edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses
// derived from the synchronised level and one extra delay flop.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_o,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_c = sync_o & ~prev_q;
    assign fall_c = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder oversampled in the clk domain. Optional sticky
// overrun/underrun flags are built when SPI_SLAVE_STATUS_EN is defined.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned       WIDTH       = SPI_WIDTH_DEFAULT,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]  IDLE_FILL   = WIDTH'(SPI_IDLE_FILL_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
`ifdef SPI_SLAVE_STATUS_EN
    output logic             overrun,
    output logic             underrun,
`endif
    output logic             rx_valid
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
    logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;
    logic lead_c, trail_c, sample_c, shift_c;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .sync_o(unused_sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs_n),
        .sync_o(unused_cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .sync_o(mosi_sync), .rise_c(unused_mosi_rise), .fall_c(unused_mosi_fall)
    );

    // Map physical sclk edges onto sample/shift events for the configured mode
    assign lead_c   = SPI_CPOL ? sclk_fall : sclk_rise;
    assign trail_c  = SPI_CPOL ? sclk_rise : sclk_fall;
    assign sample_c = SPI_CPHA ? trail_c : lead_c;
    assign shift_c  = SPI_CPHA ? lead_c : trail_c;

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             tx_ready_q, tx_ready_d;
    logic             miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d;
    logic             rx_valid_q, rx_valid_d;
    logic             reload_q, reload_d;
    logic             do_load, miso_upd;
`ifdef SPI_SLAVE_STATUS_EN
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        rx_data_d  = rx_data_q;
        tx_ready_d = tx_ready_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        rx_valid_d = 1'b0;
        reload_d   = reload_q;
        do_load    = 1'b0;
        miso_upd   = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
`endif

        if (cs_rise) begin
            // Deselect discards any partial frame but keeps the holding buffer
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            miso_d     = 1'b0;
            miso_oe_d  = 1'b0;
            reload_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    do_load   = 1'b1;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                    miso_oe_d = 1'b1;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sample_c) begin
                        rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_sync};
                        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                            reload_d   = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_c) begin
                        // First shift edge after a completed frame reloads instead
                        if (reload_q) begin
                            do_load  = 1'b1;
                            reload_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                            miso_upd   = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (do_load) begin
            if (!tx_ready_q) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d = IDLE_FILL;
`ifdef SPI_SLAVE_STATUS_EN
                underrun_d = 1'b1;
`endif
            end
            miso_upd = 1'b1;
        end

        if (miso_upd) begin
            miso_d = tx_shift_d[WIDTH-1];
        end

        // A write landing on the load that empties the buffer is accepted
        if (tx_wr) begin
            if (tx_ready_d) begin
                hold_d     = tx_data;
                tx_ready_d = 1'b0;
            end else begin
`ifdef SPI_SLAVE_STATUS_EN
                overrun_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            hold_q     <= '0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b1;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            reload_q   <= 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            rx_valid_q <= rx_valid_d;
            reload_q   <= reload_d;
`ifdef SPI_SLAVE_STATUS_EN
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_STATUS_EN
    assign overrun  = overrun_q;
    assign underrun = underrun_q;
`endif

endmodule
